// File: rtl/dot_product_sequencer.sv
// rtl/dot_product_sequencer.sv - dual-pair multiply-add dot product job sequencer
//
// Accepts a job of len beats. Each beat contributes a1*b1 + a2*b2, computed
// in a two-stage pipeline (products, then pair sum) and accumulated into a
// 32-bit result. All arithmetic is unsigned and keeps the low 32 bits.
//
// Optional feature macro: DOTSEQ_SATURATE_EN
//   defined   : accumulate clamps to 32'hFFFFFFFF on unsigned overflow
//   undefined : accumulate wraps modulo 2^32
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous reset, active-high
//   start      in   1   begin job (sampled only in IDLE)
//   len        in   8   job length in beats (sampled with start)
//   in_valid   in   1   beat operands valid
//   in_ready   out  1   beat accepted when in_valid && in_ready (FEED only)
//   a1, a2     in   32  operand A pair
//   b1, b2     in   32  operand B pair
//   res_valid  out  1   result valid, held until res_ready
//   res_ready  in   1   result consumer ready
//   result     out  32  accumulated dot product
//   busy       out  1   high whenever not IDLE

module dot_product_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  len,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a1,
    input  logic [31:0] a2,
    input  logic [31:0] b1,
    input  logic [31:0] b2,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  cnt;
    logic [31:0] prod1;
    logic [31:0] prod2;
    logic [31:0] sum;
    logic [31:0] acc;
    logic [31:0] acc_nx;
    logic        s1_vld;
    logic        s2_vld;
    logic        accept;
    logic        last_beat;

    assign accept    = (state == FEED) && in_valid;
    // cnt is never zero in FEED, so the final beat is the one seen at cnt == 1
    assign last_beat = accept && (cnt == 8'd1);
    assign result    = acc;

`ifdef DOTSEQ_SATURATE_EN
    logic [32:0] acc_ext;
    assign acc_ext = {1'b0, acc} + {1'b0, sum};
    assign acc_nx  = acc_ext[32] ? 32'hFFFF_FFFF : acc_ext[31:0];
`else
    assign acc_nx  = acc + sum;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = (len == 8'd0) ? DONE : FEED;
                end
            end
            FEED: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                // Stage 1 is empty and stage 2 holds the final sum: it is
                // accumulated on this edge, so the result is complete after it.
                if (s2_vld && !s1_vld) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= 8'd0;
            prod1  <= 32'd0;
            prod2  <= 32'd0;
            sum    <= 32'd0;
            acc    <= 32'd0;
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            s1_vld <= accept;
            s2_vld <= s1_vld;
            if (accept) begin
                prod1 <= a1 * b1;
                prod2 <= a2 * b2;
                cnt   <= cnt - 8'd1;
            end
            if (s1_vld) begin
                sum <= prod1 + prod2;
            end
            if ((state == IDLE) && start) begin
                acc <= 32'd0;
                cnt <= len;
            end else if (s2_vld) begin
                acc <= acc_nx;
            end
        end
    end

endmodule
